dm_sba_target: RTL
==================

# dm_sba_target

Bus target that answers the debug module's system-bus-access master on the req/gnt/r_valid protocol. It is backed by a word-addressed register-file memory with byte-enable writes, a configurable grant delay and a fixed response latency. It sits at the far end of the SBA port in simulation benches and small SoC configurations. It also flags out-of-range accesses.

## Interface
- BusWidth, 32: data/address width; 32 or 64.
- NumWords, 256: memory depth in BusWidth words; power of two, ≥2.
- GntDelay, 0: cycles a request must be held before grant; 0..15.
- RespLatency, 1: cycles from grant cycle to r_valid; 1..4.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- stall_i  in  1  forces slave_gnt_o low while high (bench back-pressure).
- slave_req_i  in  1  request valid.
- slave_add_i  in  BusWidth  byte address.
- slave_we_i  in  1  1 = write, 0 = read.
- slave_wdata_i  in  BusWidth  write data, lane-aligned.
- slave_be_i  in  BusWidth/8  byte enables (writes only).
- slave_gnt_o  out  1  request accepted this cycle.
- slave_r_valid_o  out  1  response valid (reads and writes).
- slave_r_rdata_o  out  BusWidth  read data; 0 for writes.
- slave_r_err_o  out  1  response is for an out-of-range access; qualified by r_valid.

## Operation
- Byte offset bits: ByteOff = $clog2(BusWidth/8). Word index = add[ByteOff +: $clog2(NumWords)]. In range iff all bits above the index are 0.
- Grant: slave_gnt_o = req & ~stall_i & (wait_cnt == GntDelay). slave_gnt_o is combinational from slave_req_i/stall_i; it never depends on r_valid.
- wait_cnt (4-bit):
  - increments each cycle req is high, not granted and below GntDelay;
  - saturates at GntDelay;
  - clears on grant or when req is low.
  - stall_i does not clear it.
- On grant, write:
  - in range: each byte lane i with be[i]=1 takes wdata lane i; other lanes are unchanged.
  - out of range: memory untouched; err=1.
- On grant, read:
  - in range: captures the full word at the index; be is ignored.
  - out of range: captures 0; err=1.
- The response (valid, rdata, err) enters a RespLatency-deep shift pipeline and emerges on slave_r_valid_o/slave_r_rdata_o/slave_r_err_o. Write responses carry rdata=0.
- Throughput: one accepted request per cycle, with unlimited overlap in the pipeline. Responses return strictly in grant order.
- Memory contents are not reset. Only the control state, pipeline and outputs reset.

## Timing
- Reset values: slave_r_valid_o=0, slave_r_rdata_o=0, slave_r_err_o=0, wait_cnt=0. slave_gnt_o=0 while req is low.
- GntDelay=0: grant in the same cycle req rises, unless stalled.
- GntDelay=N: earliest grant is the N-th cycle after req rises (cycle index N, counting the rise cycle as 0).
- Response: a grant in cycle t gives r_valid high in cycle t+RespLatency for exactly one cycle.
- Read after write: a write granted in cycle t is visible to a read granted in cycle t+1.
- Simultaneous events:
  - new grant while an older response exits: both happen, with no stall.
  - stall_i rising in the cycle wait_cnt reaches GntDelay: no grant; grant comes in the first cycle after stall_i falls.
- req dropping before grant: the request is abandoned, wait_cnt clears, and nothing is written.
- Async reset mid-transaction: pipeline flushes; in-flight responses are lost. Writes already granted remain in memory.

## Test plan
- GntDelay=0, RespLatency=1: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 → gnt in the req cycle; read r_valid one cycle after grant with rdata=0xDEADBEEF, err=0.
- Partial write: start from 0x11223344 at 0x20, write 0xAABBCCDD with be=0x6 → later read returns 0x11BBCC44.
- GntDelay=3, stall_i pulsed high in cycles 2-4 after req → gnt in cycle 5; wait_cnt does not restart. Separately, req dropped at cycle 2 → no grant and memory unchanged.
- RespLatency=3, back-to-back reads of 0x0, 0x4, 0x8 in consecutive cycles → three consecutive r_valid cycles, 3 cycles after each grant, in order, with matching data.
- Out of range (NumWords=256, BusWidth=32): read 0x400 → rdata=0, err=1; write 0x400 → err=1; address 0x000 still holds its prior value.
- Assert rst_ni low with two responses in flight → r_valid stays 0 after release. A read of the previously written address returns the written data.

Source files
------------

// File: rtl/dm_sba_target.sv
// dm_sba_target: far-end responder for the debug module's system-bus-access
// master on the req/gnt/r_valid protocol. It has a word-addressed register-file
// memory with byte-enable writes, a programmable grant delay, a fixed-latency
// response pipeline and out-of-range error flagging.
//
// Handshake: a request is accepted in any cycle where slave_req_i and
// slave_gnt_o are both high. Each accepted request, read or write, produces
// exactly one slave_r_valid_o pulse RespLatency cycles later. Responses come
// back in acceptance order. slave_r_rdata_o and slave_r_err_o are only
// meaningful while slave_r_valid_o is high. There is no response back-pressure.
module dm_sba_target #(
  parameter int BusWidth    = 32,
  parameter int NumWords    = 256,
  parameter int GntDelay    = 0,
  parameter int RespLatency = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  slave_req_i,
  input  logic [BusWidth-1:0]   slave_add_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  output logic                  slave_gnt_o,
  output logic                  slave_r_valid_o,
  output logic [BusWidth-1:0]   slave_r_rdata_o,
  output logic                  slave_r_err_o
);

  localparam int NumBytes = BusWidth / 8;
  localparam int ByteOff  = $clog2(NumBytes);
  localparam int IdxW     = $clog2(NumWords);
  localparam logic [3:0] GntDelayW = 4'(GntDelay);

  // Backing store. It is deliberately left out of reset.
  logic [BusWidth-1:0] r_mem [NumWords];

  logic [3:0]          r_wait_cnt;
  logic [IdxW-1:0]     w_idx;
  logic                w_in_range;
  logic                w_gnt;
  logic [BusWidth-1:0] w_rdata;
  logic                w_err;

  // Response pipeline. Stage 0 is loaded in the grant cycle, and the last
  // stage drives the outputs.
  logic                r_pv [RespLatency];
  logic [BusWidth-1:0] r_pd [RespLatency];
  logic                r_pe [RespLatency];

  // The byte-offset bits do not select anything in a word-wide memory.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^slave_add_i[ByteOff-1:0];

  assign w_idx      = slave_add_i[ByteOff +: IdxW];
  assign w_in_range = ((slave_add_i >> (ByteOff + IdxW)) == '0);

  // Grant is purely combinational from req, stall and the wait counter.
  assign w_gnt       = slave_req_i & ~stall_i & (r_wait_cnt == GntDelayW);
  assign slave_gnt_o = w_gnt;

  // Count the cycles a request has been held. The counter saturates at
  // GntDelay so that a stall does not restart the wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= 4'd0;
    end else if (!slave_req_i || w_gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt < GntDelayW) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Byte-lane write on an accepted, in-range write. Out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (w_gnt && slave_we_i && w_in_range) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (slave_be_i[i]) begin
          r_mem[w_idx][i*8 +: 8] <= slave_wdata_i[i*8 +: 8];
        end
      end
    end
  end

  // Build the response in the grant cycle. Read data is zero for writes, for
  // errors and for idle cycles.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    if (w_gnt) begin
      w_err = ~w_in_range;
      if (!slave_we_i && w_in_range) begin
        w_rdata = r_mem[w_idx];
      end
    end
  end

  // Shift the response through RespLatency stages. Reset flushes in-flight responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < RespLatency; s++) begin
        r_pv[s] <= 1'b0;
        r_pd[s] <= '0;
        r_pe[s] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_gnt;
      r_pd[0] <= w_rdata;
      r_pe[0] <= w_err;
      for (int s = 1; s < RespLatency; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pd[s] <= r_pd[s-1];
        r_pe[s] <= r_pe[s-1];
      end
    end
  end

  assign slave_r_valid_o = r_pv[RespLatency-1];
  assign slave_r_rdata_o = r_pd[RespLatency-1];
  assign slave_r_err_o   = r_pe[RespLatency-1];

endmodule
